itim_assoc: RTL

- Parametrised next-generation instruction tightly-integrated memory.
- N-way set-associative, multi-word lines, whole-line refill from the instruction memory bus, round-robin replacement, uncacheable-region bypass and a fence-driven invalidation sweep.
- Sits between the fetch stage (itim_in/itim_out) and the instruction memory port (imem_in/imem_out), both of mem_in_type/mem_out_type from the wires package.

---
 rtl/wires.sv | 18 +
 rtl/itim_assoc_chk.sv | 14 +
 rtl/itim_assoc.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wires.sv
// Shared memory-bus request/response types used on both sides of the ITIM.
package wires;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_fence;
      logic        mem_instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic [31:0] mem_rdata;
      logic        mem_ready;
   } mem_out_type;

endpackage

// File: rtl/itim_assoc_chk.sv
// Invariant checker for itim_assoc: a lookup never matches more than one way.
module itim_assoc_chk #(
   parameter int ways = 2
) (
   input logic            clock,
   input logic            reset,
   input logic            lookup,
   input logic [ways-1:0] match
);

   // At most one way may hold the looked-up tag in a given set.
   a_onehot_match: assert property (@(posedge clock) disable iff (!reset) lookup |-> $onehot0(match));

endmodule

// File: rtl/itim_assoc.sv
// N-way set-associative instruction TIM with whole-line refill, round-robin
// replacement, uncacheable bypass and a one-set-per-cycle fence sweep.
module itim_assoc
   import wires::*;
#(
   parameter int          ways       = 2,
   parameter int          sets       = 64,
   parameter int          line_words = 4,
   parameter logic [31:0] base_addr  = 32'h0,
   parameter logic [31:0] top_addr   = 32'h10000
) (
   input  logic        clock,
   input  logic        reset,
   input  mem_in_type  itim_in,
   output mem_out_type itim_out,
   input  mem_out_type imem_out,
   output mem_in_type  imem_in
);

   localparam int          OFF       = $clog2(line_words);
   localparam int          IDX       = $clog2(sets);
   localparam int          OFF_W     = (OFF > 0) ? OFF : 1;
   localparam int          WAY_W     = (ways > 1) ? $clog2(ways) : 1;
   localparam int          TAG_W     = 30 - OFF - IDX;
   localparam logic [31:0] LINE_MASK = 32'(line_words * 4 - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_REFILL, ST_BYPASS, ST_FENCE} state_t;

   state_t           state_q, state_d;
   logic [31:0]      req_addr_q, req_addr_d;
   logic [OFF_W-1:0] cnt_q, cnt_d;
   logic [IDX-1:0]   set_q, set_d;
   logic [WAY_W-1:0] victim_q, victim_d;
   logic [WAY_W-1:0] ptr_q, ptr_d;
   logic             use_ptr_q, use_ptr_d;
   logic [31:0]      capt_q, capt_d;
   logic [sets-1:0]  valid_q [ways];
   logic [sets-1:0]  valid_d [ways];

   logic [TAG_W-1:0] tag_mem  [ways][sets];
   logic [31:0]      data_mem [ways][sets][line_words];

   logic [OFF_W-1:0] req_word_s;
   logic [IDX-1:0]   req_idx_s;
   logic [TAG_W-1:0] req_tag_s;
   logic             in_range_s;
   logic [ways-1:0]  match_s;
   logic [31:0]      hit_data_s;
   logic [WAY_W-1:0] victim_s;
   logic             free_s;
   logic [WAY_W-1:0] ptr_inc_s;
   logic             ready_s;
   logic [31:0]      rdata_s;
   logic             accept_s;
   logic             take_s;
   logic             fill_we_s;
   logic             tag_we_s;
   logic             imem_valid_s;
   logic [31:0]      imem_addr_s;
   logic             lookup_s;
   logic             unused_s;

   assign req_word_s = OFF_W'(req_addr_q[31:2] & 30'(line_words - 1));
   assign req_idx_s  = req_addr_q[OFF+IDX+1:OFF+2];
   assign req_tag_s  = req_addr_q[31:OFF+IDX+2];
   // Unsigned offset compare keeps the range check correct even when base_addr is 0.
   assign in_range_s = (req_addr_q - base_addr) < (top_addr - base_addr);
   assign ptr_inc_s  = (ptr_q == WAY_W'(ways - 1)) ? '0 : ptr_q + WAY_W'(1);
   assign lookup_s   = (state_q == ST_LOOKUP);
   assign unused_s   = ^{itim_in.mem_instr, itim_in.mem_wdata, itim_in.mem_wstrb};

   // Tag compare across all ways and victim choice (lowest invalid way, else pointer).
   always_comb begin
      match_s    = '0;
      hit_data_s = 32'h0;
      victim_s   = ptr_q;
      free_s     = 1'b0;
      for (int w = ways - 1; w >= 0; w--) begin
         match_s[w] = valid_q[w][req_idx_s] && (tag_mem[w][req_idx_s] == req_tag_s);
         hit_data_s = hit_data_s | ({32{match_s[w]}} & data_mem[w][req_idx_s][req_word_s]);
         victim_s   = !valid_q[w][req_idx_s] ? WAY_W'(w) : victim_s;
         free_s     = free_s | !valid_q[w][req_idx_s];
      end
   end

   // Next-state logic, array write strobes and both bus responses.
   always_comb begin
      state_d      = state_q;
      req_addr_d   = req_addr_q;
      cnt_d        = cnt_q;
      set_d        = set_q;
      victim_d     = victim_q;
      use_ptr_d    = use_ptr_q;
      ptr_d        = ptr_q;
      capt_d       = capt_q;
      valid_d      = valid_q;
      ready_s      = 1'b0;
      rdata_s      = 32'h0;
      accept_s     = 1'b0;
      fill_we_s    = 1'b0;
      tag_we_s     = 1'b0;
      imem_valid_s = 1'b0;
      imem_addr_s  = req_addr_q;
      case (state_q)
         ST_IDLE: begin
            accept_s = 1'b1;
         end
         ST_LOOKUP: begin
            if (!in_range_s) begin
               state_d = ST_BYPASS;
            end else if (|match_s) begin
               ready_s  = 1'b1;
               rdata_s  = hit_data_s;
               accept_s = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               // Drop the victim up front so an abandoned refill never leaves a half line.
               state_d   = ST_REFILL;
               cnt_d     = '0;
               victim_d  = victim_s;
               use_ptr_d = !free_s;
               valid_d[victim_s][req_idx_s] = 1'b0;
            end
         end
         ST_REFILL: begin
            imem_valid_s = 1'b1;
            imem_addr_s  = (req_addr_q & ~LINE_MASK) | (32'(cnt_q) << 2);
            if (imem_out.mem_ready) begin
               fill_we_s = 1'b1;
               capt_d    = (cnt_q == req_word_s) ? imem_out.mem_rdata : capt_q;
               if (cnt_q == OFF_W'(line_words - 1)) begin
                  tag_we_s = 1'b1;
                  valid_d[victim_q][req_idx_s] = 1'b1;
                  ready_s  = 1'b1;
                  rdata_s  = capt_d;
                  accept_s = 1'b1;
                  state_d  = ST_IDLE;
                  ptr_d    = use_ptr_q ? ptr_inc_s : ptr_q;
               end else begin
                  cnt_d = cnt_q + OFF_W'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_BYPASS: begin
            imem_valid_s = 1'b1;
            if (imem_out.mem_ready) begin
               ready_s  = 1'b1;
               rdata_s  = imem_out.mem_rdata;
               accept_s = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_BYPASS;
            end
         end
         ST_FENCE: begin
            for (int w = 0; w < ways; w++) begin
               valid_d[w][set_q] = 1'b0;
            end
            if (set_q == IDX'(sets - 1)) begin
               ready_s  = 1'b1;
               accept_s = 1'b1;
               ptr_d    = '0;
               state_d  = ST_IDLE;
            end else begin
               set_d = set_q + IDX'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A new request may be taken in any cycle that completes the previous one.
      take_s     = accept_s && itim_in.mem_valid;
      req_addr_d = take_s ? itim_in.mem_addr : req_addr_d;
      set_d      = take_s ? '0 : set_d;
      state_d    = take_s ? (itim_in.mem_fence ? ST_FENCE : ST_LOOKUP) : state_d;
   end

   // Control and valid state, cleared asynchronously.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         req_addr_q <= 32'h0;
         cnt_q      <= '0;
         set_q      <= '0;
         victim_q   <= '0;
         ptr_q      <= '0;
         use_ptr_q  <= 1'b0;
         capt_q     <= 32'h0;
         for (int w = 0; w < ways; w++) begin
            valid_q[w] <= '0;
         end
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         cnt_q      <= cnt_d;
         set_q      <= set_d;
         victim_q   <= victim_d;
         ptr_q      <= ptr_d;
         use_ptr_q  <= use_ptr_d;
         capt_q     <= capt_d;
         valid_q    <= valid_d;
      end
   end

   // Tag and line storage, written only by refill and never reset.
   always_ff @(posedge clock) begin
      if (fill_we_s) begin
         data_mem[victim_q][req_idx_s][cnt_q] <= imem_out.mem_rdata;
      end
      if (tag_we_s) begin
         tag_mem[victim_q][req_idx_s] <= req_tag_s;
      end
   end

   // Drive the response and request structs; unused request fields are fixed.
   always_comb begin
      itim_out           = '0;
      itim_out.mem_ready = ready_s;
      itim_out.mem_rdata = rdata_s;
      imem_in            = '0;
      imem_in.mem_valid  = imem_valid_s;
      imem_in.mem_instr  = 1'b1;
      imem_in.mem_addr   = imem_addr_s;
   end

   itim_assoc_chk #(.ways(ways)) u_chk (
      .clock  (clock),
      .reset  (reset),
      .lookup (lookup_s),
      .match  (match_s)
   );

endmodule
